// File: rtl/rom_loader.sv
// Boot-time copy engine: streams WORDS words from flash to RAM one at a time,
// then reads the trailing flash checksum word and releases the CPU on a match.
module rom_loader #(
   parameter logic [20:0] SRC_BASE = 21'h000000,
   parameter logic [23:0] DST_BASE = 24'h000000,
   parameter logic [15:0] WORDS    = 16'd1024
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        rom_en,
   output logic        rom_wr,
   output logic [1:0]  rom_size,
   output logic [20:0] rom_addr,
   input  logic [31:0] rom_data,
   input  logic        rom_wt,
   output logic        ram_en,
   output logic        ram_wr,
   output logic [1:0]  ram_size,
   output logic [23:0] ram_addr,
   output logic [31:0] ram_data_out,
   input  logic        ram_wt,
   output logic        done,
   output logic        error,
   output logic        cpu_reset_n
);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_CHECK, S_DONE} state_t;

   state_t      state_q, state_d;
   logic        rom_en_q, rom_en_d;
   logic [20:0] rom_addr_q, rom_addr_d;
   logic        ram_en_q, ram_en_d;
   logic [23:0] ram_addr_q, ram_addr_d;
   logic [31:0] data_q, data_d;
   logic [31:0] sum_q, sum_d;
   logic [15:0] cnt_q, cnt_d;
   logic        bad_q, bad_d;
   logic        done_q, done_d;
   logic        error_q, error_d;
   logic        cpu_q, cpu_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         rom_en_q   <= 1'b0;
         rom_addr_q <= '0;
         ram_en_q   <= 1'b0;
         ram_addr_q <= '0;
         data_q     <= '0;
         sum_q      <= '0;
         cnt_q      <= '0;
         bad_q      <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         cpu_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rom_en_q   <= rom_en_d;
         rom_addr_q <= rom_addr_d;
         ram_en_q   <= ram_en_d;
         ram_addr_q <= ram_addr_d;
         data_q     <= data_d;
         sum_q      <= sum_d;
         cnt_q      <= cnt_d;
         bad_q      <= bad_d;
         done_q     <= done_d;
         error_q    <= error_d;
         cpu_q      <= cpu_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rom_en_d   = rom_en_q;
      rom_addr_d = rom_addr_q;
      ram_en_d   = ram_en_q;
      ram_addr_d = ram_addr_q;
      data_d     = data_q;
      sum_d      = sum_q;
      cnt_d      = cnt_q;
      bad_d      = bad_q;
      done_d     = done_q;
      error_d    = error_q;
      cpu_d      = cpu_q;
      case (state_q)
         S_IDLE: state_d = (WORDS != 16'd0) ? S_READ : S_CHECK;
         // CHECK reuses the read path: with cnt_q == WORDS the address lands on the checksum word.
         S_READ, S_CHECK: begin
            if (!rom_en_q) begin
               rom_en_d   = 1'b1;
               rom_addr_d = SRC_BASE + 21'({cnt_q, 2'b00});
            end else if (!rom_wt) begin
               rom_en_d = 1'b0;
               if (state_q == S_READ) begin
                  data_d  = rom_data;
                  sum_d   = sum_q + rom_data;
                  state_d = S_WRITE;
               end else begin
                  bad_d   = (rom_data != sum_q);
                  state_d = S_DONE;
               end
            end
         end
         S_WRITE: begin
            if (!ram_en_q) begin
               ram_en_d   = 1'b1;
               ram_addr_d = DST_BASE + 24'({cnt_q, 2'b00});
            end else if (!ram_wt) begin
               ram_en_d = 1'b0;
               cnt_d    = cnt_q + 16'd1;
               state_d  = (cnt_q + 16'd1 == WORDS) ? S_CHECK : S_READ;
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            error_d = bad_q;
            cpu_d   = !bad_q;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign rom_en       = rom_en_q;
   assign rom_wr       = 1'b0;
   assign rom_size     = 2'b10;
   assign rom_addr     = rom_addr_q;
   assign ram_en       = ram_en_q;
   assign ram_wr       = ram_en_q;
   assign ram_size     = 2'b10;
   assign ram_addr     = ram_addr_q;
   assign ram_data_out = data_q;
   assign done         = done_q;
   assign error        = error_q;
   assign cpu_reset_n  = cpu_q;

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: flash/RAM responders with programmable latency, a
// wrapping-address main instance and a zero-word instance.
module tb_rom_loader;
   localparam logic [20:0] SRC_A = 21'h1FFFF8;
   localparam logic [23:0] DST_A = 24'hFFFFF4;
   localparam logic [20:0] SRC_Z = 21'h000100;
   localparam logic [23:0] DST_Z = 24'h000200;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n = 1'b0;
   logic rom_en, rom_wr, ram_en, ram_wr, done, error, cpu_reset_n;
   logic [1:0] rom_size, ram_size;
   logic [20:0] rom_addr;
   logic [23:0] ram_addr;
   logic [31:0] ram_data_out;
   logic [31:0] rom_data = '0;
   logic rom_wt = 1'b1, ram_wt = 1'b1;

   logic rst0_n = 1'b0;
   logic z_rom_en, z_rom_wr, z_ram_en, z_ram_wr, z_done, z_error, z_cpu;
   logic [1:0] z_rom_size, z_ram_size;
   logic [20:0] z_rom_addr;
   logic [23:0] z_ram_addr;
   logic [31:0] z_ram_data;
   logic [31:0] z_rom_data = '0;
   logic z_rom_wt = 1'b1;
   logic z_ram_wt = 1'b1;

   rom_loader #(.SRC_BASE(SRC_A), .DST_BASE(DST_A), .WORDS(16'd4)) dut (
      .clk(clk), .reset_n(reset_n), .rom_en(rom_en), .rom_wr(rom_wr), .rom_size(rom_size),
      .rom_addr(rom_addr), .rom_data(rom_data), .rom_wt(rom_wt), .ram_en(ram_en),
      .ram_wr(ram_wr), .ram_size(ram_size), .ram_addr(ram_addr), .ram_data_out(ram_data_out),
      .ram_wt(ram_wt), .done(done), .error(error), .cpu_reset_n(cpu_reset_n));

   rom_loader #(.SRC_BASE(SRC_Z), .DST_BASE(DST_Z), .WORDS(16'd0)) dut0 (
      .clk(clk), .reset_n(rst0_n), .rom_en(z_rom_en), .rom_wr(z_rom_wr), .rom_size(z_rom_size),
      .rom_addr(z_rom_addr), .rom_data(z_rom_data), .rom_wt(z_rom_wt), .ram_en(z_ram_en),
      .ram_wr(z_ram_wr), .ram_size(z_ram_size), .ram_addr(z_ram_addr), .ram_data_out(z_ram_data),
      .ram_wt(z_ram_wt), .done(z_done), .error(z_error), .cpu_reset_n(z_cpu));

   int n_tests = 0, n_fail = 0;

   // Flash / RAM behaviour for the main instance; state is cleared while reset is low.
   logic [31:0] flash [logic [20:0]];
   logic [31:0] ram_mem [logic [23:0]];
   logic [20:0] rom_log [$];
   int rom_lat = 14, ram_lat = 1;
   int rom_cnt, ram_cnt, rom_reads, ram_writes;
   int sstray_req = 0, sstray_done = 0, rstray_req = 0, rstray_done = 0;
   bit rom_unstable, ram_unstable, wr_bad;
   logic [20:0] rom_addr_h;
   logic [23:0] ram_addr_h;
   logic [31:0] ram_dat_h;

   always @(negedge clk) begin
      if (!reset_n) begin
         rom_cnt = 0; ram_cnt = 0; rom_wt = 1'b1; ram_wt = 1'b1;
         rom_reads = 0; ram_writes = 0;
         rom_unstable = 0; ram_unstable = 0; wr_bad = 0;
         ram_mem.delete(); rom_log.delete();
      end else begin
         if (ram_wr !== ram_en) wr_bad = 1;
         if (rom_en) begin
            if (rom_cnt > 0 && rom_addr !== rom_addr_h) rom_unstable = 1;
            rom_addr_h = rom_addr;
            rom_cnt++;
            if (rom_cnt == rom_lat) begin
               rom_wt = 1'b0;
               rom_data = flash.exists(rom_addr) ? flash[rom_addr] : 32'hDEAD_BEEF;
               rom_reads++;
               rom_log.push_back(rom_addr);
            end else begin
               rom_wt = 1'b1; rom_data = $urandom;
            end
         end else begin
            rom_cnt = 0; rom_data = $urandom;
            if (rstray_done < rstray_req && ram_en) begin rom_wt = 1'b0; rstray_done++; end
            else rom_wt = 1'b1;
         end
         if (ram_en) begin
            if (ram_cnt > 0 && (ram_addr !== ram_addr_h || ram_data_out !== ram_dat_h)) ram_unstable = 1;
            ram_addr_h = ram_addr; ram_dat_h = ram_data_out;
            ram_cnt++;
            if (ram_cnt == ram_lat) begin
               ram_wt = 1'b0;
               ram_mem[ram_addr] = ram_data_out;
               ram_writes++;
            end else ram_wt = 1'b1;
         end else begin
            ram_cnt = 0;
            if (sstray_done < sstray_req && rom_en) begin ram_wt = 1'b0; sstray_done++; end
            else ram_wt = 1'b1;
         end
      end
   end

   // Zero-word instance: 3-cycle flash, counts reads, flags any RAM request.
   logic [31:0] z_chk = '0;
   int z_cnt, z_reads;
   bit z_ram_seen;
   logic [20:0] z_addr;
   always @(negedge clk) begin
      if (!rst0_n) begin
         z_cnt = 0; z_reads = 0; z_ram_seen = 0; z_rom_wt = 1'b1;
      end else begin
         if (z_ram_en) z_ram_seen = 1;
         if (z_rom_en) begin
            z_cnt++;
            if (z_cnt == 3) begin
               z_rom_wt = 1'b0; z_rom_data = z_chk; z_reads++; z_addr = z_rom_addr;
            end else z_rom_wt = 1'b1;
         end else begin
            z_cnt = 0; z_rom_wt = 1'b1;
         end
      end
   end

   function automatic int exp_edges(input int nw, input int rl, input int wl);
      return 1 + nw * (rl + wl + 2) + rl + 2;
   endfunction

   task automatic load_flash(input logic [31:0] w [4], input logic [31:0] chk);
      flash.delete();
      for (int i = 0; i < 4; i++) flash[SRC_A + 21'(4 * i)] = w[i];
      flash[SRC_A + 21'(16)] = chk;
   endtask

   task automatic start(input int rl, input int wl);
      rom_lat = rl; ram_lat = wl;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic wait_done(output int edges);
      edges = 0;
      while (done !== 1'b1 && edges < 4000) begin
         @(posedge clk); #1; edges++;
      end
   endtask

   task automatic test_reset;
      logic [31:0] w [4];
      w = '{32'd1, 32'd2, 32'd3, 32'd4};
      load_flash(w, 32'd10);
      rom_lat = 14; ram_lat = 1;
      reset_n = 1'b0;
      #12;
      n_tests++; if ({rom_en, ram_en, ram_wr, done, error, cpu_reset_n} !== 6'b0) begin
         n_fail++; $display("FAIL reset_ctrl: got %b want 000000", {rom_en, ram_en, ram_wr, done, error, cpu_reset_n});
      end
      n_tests++; if (rom_addr !== 21'h0 || ram_addr !== 24'h0 || ram_data_out !== 32'h0) begin
         n_fail++; $display("FAIL reset_data: got %h %h %h want 0", rom_addr, ram_addr, ram_data_out);
      end
      n_tests++; if (rom_wr !== 1'b0 || rom_size !== 2'b10 || ram_size !== 2'b10) begin
         n_fail++; $display("FAIL reset_const: got %b %b %b want 0 10 10", rom_wr, rom_size, ram_size);
      end
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;
      n_tests++; if (rom_en !== 1'b0) begin
         n_fail++; $display("FAIL first_en_early: got %b want 0", rom_en);
      end
      @(posedge clk); #1;
      n_tests++; if (rom_en !== 1'b1 || rom_addr !== SRC_A) begin
         n_fail++; $display("FAIL first_en: got %b/%h want 1/%h", rom_en, rom_addr, SRC_A);
      end
   endtask

   task automatic test_copy_ok;
      logic [31:0] w [4];
      int e;
      w = '{32'd1, 32'd2, 32'd3, 32'd4};
      load_flash(w, 32'd10);
      start(14, 1);
      wait_done(e);
      n_tests++; if (e != 85) begin n_fail++; $display("FAIL ok_done_edge: got %0d want 85", e); end
      n_tests++; if (error !== 1'b0 || cpu_reset_n !== 1'b1) begin
         n_fail++; $display("FAIL ok_status: got err=%b cpu=%b want 0 1", error, cpu_reset_n);
      end
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (!ram_mem.exists(DST_A + 24'(4 * i)) || ram_mem[DST_A + 24'(4 * i)] !== w[i]) begin
            n_fail++; $display("FAIL ok_ram%0d: missing or wrong want %h", i, w[i]);
         end
      end
      n_tests++; if (rom_log.size() != 5) begin
         n_fail++; $display("FAIL ok_reads: got %0d want 5", rom_log.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_tests++; if (rom_log[i] !== SRC_A + 21'(4 * i)) begin
               n_fail++; $display("FAIL ok_rom_addr%0d: got %h want %h", i, rom_log[i], SRC_A + 21'(4 * i));
            end
         end
      end
      n_tests++; if (rom_unstable || wr_bad) begin
         n_fail++; $display("FAIL ok_handshake: got unstable=%0d wr_bad=%0d want 0 0", rom_unstable, wr_bad);
      end
      repeat (20) @(posedge clk);
      #1;
      n_tests++; if (done !== 1'b1 || rom_en !== 1'b0 || ram_en !== 1'b0 || rom_reads != 5) begin
         n_fail++; $display("FAIL ok_sticky: got done=%b en=%b%b reads=%0d want 1 00 5", done, rom_en, ram_en, rom_reads);
      end
   endtask

   task automatic test_bad_checksum;
      logic [31:0] w [4];
      int e;
      w = '{32'd1, 32'd2, 32'd3, 32'd4};
      load_flash(w, 32'd11);
      start(14, 1);
      wait_done(e);
      n_tests++; if (e != 85 || error !== 1'b1 || cpu_reset_n !== 1'b0) begin
         n_fail++; $display("FAIL bad_sum: got edge=%0d err=%b cpu=%b want 85 1 0", e, error, cpu_reset_n);
      end
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (!ram_mem.exists(DST_A + 24'(4 * i)) || ram_mem[DST_A + 24'(4 * i)] !== w[i]) begin
            n_fail++; $display("FAIL bad_ram%0d: missing or wrong want %h", i, w[i]);
         end
      end
   endtask

   task automatic test_sum_wrap;
      logic [31:0] w [4];
      int e;
      w = '{32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0};
      load_flash(w, 32'h1);
      start(5, 2);
      wait_done(e);
      n_tests++; if (e != exp_edges(4, 5, 2) || error !== 1'b0 || cpu_reset_n !== 1'b1) begin
         n_fail++; $display("FAIL sum_wrap: got edge=%0d err=%b cpu=%b want %0d 0 1", e, error, cpu_reset_n, exp_edges(4, 5, 2));
      end
   endtask

   task automatic test_ram_wait_stray;
      logic [31:0] w [4];
      logic [31:0] s;
      int e, sreq, rreq;
      s = '0;
      for (int i = 0; i < 4; i++) begin w[i] = $urandom; s += w[i]; end
      load_flash(w, s);
      sreq = sstray_done + 1; rreq = rstray_done + 1;
      sstray_req = sreq; rstray_req = rreq;
      start(14, 5);
      wait_done(e);
      n_tests++; if (e != exp_edges(4, 14, 5)) begin
         n_fail++; $display("FAIL wait_done_edge: got %0d want %0d", e, exp_edges(4, 14, 5));
      end
      n_tests++; if (sstray_done != sreq || rstray_done != rreq) begin
         n_fail++; $display("FAIL wait_stray_fired: got %0d %0d want %0d %0d", sstray_done, rstray_done, sreq, rreq);
      end
      n_tests++; if (ram_writes != 4 || rom_reads != 5 || ram_unstable || error !== 1'b0) begin
         n_fail++; $display("FAIL wait_counts: got w=%0d r=%0d unstable=%0d err=%b want 4 5 0 0", ram_writes, rom_reads, ram_unstable, error);
      end
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (!ram_mem.exists(DST_A + 24'(4 * i)) || ram_mem[DST_A + 24'(4 * i)] !== w[i]) begin
            n_fail++; $display("FAIL wait_ram%0d: missing or wrong want %h", i, w[i]);
         end
      end
   endtask

   task automatic test_reset_midwrite;
      logic [31:0] w [4];
      logic [31:0] s;
      int e, k;
      s = '0;
      for (int i = 0; i < 4; i++) begin w[i] = $urandom; s += w[i]; end
      load_flash(w, s);
      start(4, 3);
      k = 0;
      while (!(ram_en === 1'b1 && ram_writes == 2) && k < 2000) begin
         @(posedge clk); #1; k++;
      end
      n_tests++; if (k >= 2000) begin n_fail++; $display("FAIL mid_reach: got timeout want 3rd write"); end
      reset_n = 1'b0;
      #1;
      n_tests++; if ({rom_en, ram_en, ram_wr, done, error, cpu_reset_n} !== 6'b0 ||
                     ram_addr !== 24'h0 || ram_data_out !== 32'h0 || rom_addr !== 21'h0) begin
         n_fail++; $display("FAIL mid_reset_vals: got %b %h %h %h want 0", {rom_en, ram_en, ram_wr, done, error, cpu_reset_n}, ram_addr, ram_data_out, rom_addr);
      end
      repeat (2) @(posedge clk);
      @(negedge clk); reset_n = 1'b1;
      wait_done(e);
      n_tests++; if (e != exp_edges(4, 4, 3) || error !== 1'b0 || ram_writes != 4) begin
         n_fail++; $display("FAIL mid_rerun: got edge=%0d err=%b w=%0d want %0d 0 4", e, error, ram_writes, exp_edges(4, 4, 3));
      end
      n_tests++; if (rom_log.size() == 0 || rom_log[0] !== SRC_A) begin
         n_fail++; $display("FAIL mid_restart_addr: got %0d reads want first at %h", rom_log.size(), SRC_A);
      end
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (!ram_mem.exists(DST_A + 24'(4 * i)) || ram_mem[DST_A + 24'(4 * i)] !== w[i]) begin
            n_fail++; $display("FAIL mid_ram%0d: missing or wrong want %h", i, w[i]);
         end
      end
   endtask

   task automatic test_zero_words;
      int e;
      for (int pass = 0; pass < 2; pass++) begin
         z_chk = (pass == 0) ? 32'h0 : 32'h5;
         rst0_n = 1'b0;
         repeat (2) @(posedge clk);
         @(negedge clk); rst0_n = 1'b1;
         e = 0;
         while (z_done !== 1'b1 && e < 200) begin @(posedge clk); #1; e++; end
         n_tests++; if (e != exp_edges(0, 3, 1)) begin
            n_fail++; $display("FAIL zero_done_edge: got %0d want %0d", e, exp_edges(0, 3, 1));
         end
         n_tests++; if (z_reads != 1 || z_addr !== SRC_Z || z_ram_seen) begin
            n_fail++; $display("FAIL zero_access: got reads=%0d addr=%h ram=%0d want 1 %h 0", z_reads, z_addr, z_ram_seen, SRC_Z);
         end
         n_tests++; if (z_error !== (pass == 1) || z_cpu !== (pass == 0)) begin
            n_fail++; $display("FAIL zero_status%0d: got err=%b cpu=%b want %0d %0d", pass, z_error, z_cpu, pass == 1, pass == 0);
         end
      end
   endtask

   task automatic test_random;
      logic [31:0] w [4];
      logic [31:0] s, chk;
      int e, rl, wl;
      bit bad;
      for (int it = 0; it < 4; it++) begin
         s = '0;
         for (int i = 0; i < 4; i++) begin w[i] = $urandom; s += w[i]; end
         rl = $urandom_range(1, 16); wl = $urandom_range(1, 6);
         bad = 1'($urandom_range(0, 1));
         chk = bad ? s + 32'($urandom_range(1, 1000)) : s;
         load_flash(w, chk);
         start(rl, wl);
         wait_done(e);
         n_tests++; if (e != exp_edges(4, rl, wl) || error !== bad || cpu_reset_n !== !bad) begin
            n_fail++; $display("FAIL rand%0d_status: got edge=%0d err=%b cpu=%b want %0d %0d %0d", it, e, error, cpu_reset_n, exp_edges(4, rl, wl), bad, !bad);
         end
         n_tests++; if (rom_reads != 5 || ram_writes != 4 || rom_unstable || ram_unstable || wr_bad) begin
            n_fail++; $display("FAIL rand%0d_bus: got r=%0d w=%0d flags=%0d%0d%0d want 5 4 000", it, rom_reads, ram_writes, rom_unstable, ram_unstable, wr_bad);
         end
         for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (!ram_mem.exists(DST_A + 24'(4 * i)) || ram_mem[DST_A + 24'(4 * i)] !== w[i]) begin
               n_fail++; $display("FAIL rand%0d_ram%0d: missing or wrong want %h", it, i, w[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_copy_ok();
      test_bad_checksum();
      test_sum_wrap();
      test_ram_wait_stray();
      test_reset_midwrite();
      test_zero_words();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
